// File: rtl/key_input_pkg.sv
// Shared definitions for the key input path: FSM state encoding and the
// 27 MHz-derived default timing constants (also used by the LED blink modules).
package key_input_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESS_DB = 3'd1,
        HELD     = 3'd2,
        LONG     = 3'd3,
        REL_DB   = 3'd4
    } key_state_t;

    localparam int unsigned CLK_HZ               = 27_000_000;
    localparam int unsigned DEBOUNCE_10MS_CYCLES = CLK_HZ / 100;   // 270_000
    localparam int unsigned LONG_1S_CYCLES       = CLK_HZ;         // 27_000_000
    localparam int unsigned REPEAT_250MS_CYCLES  = CLK_HZ / 4;     // 6_750_000

endpackage

// File: rtl/key_input_sync_2ff.sv
// Two-flop synchronizer for an asynchronous pin; reset value is configurable
// so the output idles at the pin's inactive level.
module sync_2ff #(
    parameter bit RST_VAL = 1'b1
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_input.sv
// Push-button front end: synchronizes the raw pin, debounces it and emits
// single-cycle press / release / long-press / auto-repeat events plus a
// wrapping press counter. All outputs are registered.
module key_input
    import key_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_CYCLES,
    parameter int unsigned LONG_CYCLES     = LONG_1S_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = REPEAT_250MS_CYCLES,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned CNT_W           = 32
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       key_raw,
    output logic       key_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic [7:0] press_count
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    logic             sync_q;
    logic             k;
    key_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             long_flag, long_flag_nxt;
    logic             level_nxt;
    logic [7:0]       count_nxt;
    logic             press_nxt, release_nxt, long_nxt, repeat_nxt;

    sync_2ff #(
        .RST_VAL (ACTIVE_LOW)
    ) u_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .d         (key_raw),
        .q         (sync_q)
    );

    // Normalize polarity so that k = 1 means pressed.
    assign k = sync_q ^ ACTIVE_LOW;

    // Next-state, shared counter and event decode; a change of k always wins
    // over a terminal count reached in the same cycle.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt + CNT_W'(1);
        long_flag_nxt = long_flag;
        level_nxt     = key_level;
        count_nxt     = press_count;
        press_nxt     = 1'b0;
        release_nxt   = 1'b0;
        long_nxt      = 1'b0;
        repeat_nxt    = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt       = '0;
                long_flag_nxt = 1'b0;
                if (k) state_nxt = PRESS_DB;
            end
            PRESS_DB: begin
                if (!k) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                    press_nxt = 1'b1;
                    level_nxt = 1'b1;
                    count_nxt = press_count + 8'd1;
                end
            end
            HELD: begin
                if (!k) begin
                    state_nxt = REL_DB;
                    cnt_nxt   = '0;
                end else if (cnt == LONG_LAST) begin
                    state_nxt     = LONG;
                    cnt_nxt       = '0;
                    long_nxt      = 1'b1;
                    long_flag_nxt = 1'b1;
                end
            end
            LONG: begin
                if (!k) begin
                    state_nxt = REL_DB;
                    cnt_nxt   = '0;
                end else if (cnt == REP_LAST) begin
                    cnt_nxt    = '0;
                    repeat_nxt = 1'b1;
                end
            end
            REL_DB: begin
                if (k) begin
                    state_nxt = long_flag ? LONG : HELD;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt   = IDLE;
                    cnt_nxt     = '0;
                    release_nxt = 1'b1;
                    level_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            long_flag     <= 1'b0;
            key_level     <= 1'b0;
            press_count   <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            long_flag     <= long_flag_nxt;
            key_level     <= level_nxt;
            press_count   <= count_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
            long_pulse    <= long_nxt;
            repeat_pulse  <= repeat_nxt;
        end
    end

endmodule

// File: tb/tb_key_input.sv
// Bench for key_input: directed scenarios plus random pin activity, every
// cycle compared against a run-length based behavioural model.
module tb_key_input;

    localparam int unsigned DEB = 4;
    localparam int unsigned LNG = 20;
    localparam int unsigned REP = 5;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       key_raw = 1'b1;
    logic       key_level, press_pulse, release_pulse, long_pulse, repeat_pulse;
    logic [7:0] press_count;

    key_input #(
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LNG),
        .REPEAT_CYCLES   (REP),
        .ACTIVE_LOW      (1'b1),
        .CNT_W           (32)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .key_raw       (key_raw),
        .key_level     (key_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .repeat_pulse  (repeat_pulse),
        .press_count   (press_count)
    );

    always #5 sys_clk = ~sys_clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;

    // Observation bookkeeping
    int unsigned n_press_obs = 0, n_rel_obs = 0;
    int unsigned first_press = 0, first_rel = 0, first_long = 0, first_rep = 0;

    // Reference model: the FSM sees the pin two samples late; a level is
    // accepted after DEB+1 consecutive observations; hold time restarts
    // whenever the key comes back after a release bounce.
    bit          pin_p = 1'b0;   // 1 = pressed
    bit          m_h1, m_h2;
    bit          m_pressed, m_long;
    int unsigned m_run_on, m_run_off, m_t;
    logic [7:0]  m_cnt;
    bit          e_press, e_rel, e_long, e_rep;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_h1 = 0; m_h2 = 0; m_pressed = 0; m_long = 0;
        m_run_on = 0; m_run_off = 0; m_t = 0; m_cnt = '0;
        e_press = 0; e_rel = 0; e_long = 0; e_rep = 0;
    endtask

    task automatic model_step();
        bit obs;
        obs  = m_h2;
        m_h2 = m_h1;
        m_h1 = pin_p;
        e_press = 0; e_rel = 0; e_long = 0; e_rep = 0;
        if (!m_pressed) begin
            m_run_on = obs ? m_run_on + 1 : 0;
            if (m_run_on == DEB + 1) begin
                e_press = 1; m_pressed = 1; m_cnt++;
                m_t = 0; m_long = 0; m_run_off = 0;
            end
        end else if (!obs) begin
            m_run_off++;
            if (m_run_off == DEB + 1) begin
                e_rel = 1; m_pressed = 0; m_run_on = 0;
            end
        end else begin
            m_t = (m_run_off > 0) ? 0 : m_t + 1;
            m_run_off = 0;
            if (!m_long && m_t == LNG) begin
                e_long = 1; m_long = 1; m_t = 0;
            end else if (m_long && m_t == REP) begin
                e_rep = 1; m_t = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        if (!sys_rst_n) model_reset(); else model_step();
        cyc++;
        #1;
        check("key_level",     32'(key_level),     32'(m_pressed));
        check("press_pulse",   32'(press_pulse),   32'(e_press));
        check("release_pulse", 32'(release_pulse), 32'(e_rel));
        check("long_pulse",    32'(long_pulse),    32'(e_long));
        check("repeat_pulse",  32'(repeat_pulse),  32'(e_rep));
        check("press_count",   32'(press_count),   32'(m_cnt));
        if (press_pulse) begin n_press_obs++; if (first_press == 0) first_press = cyc; end
        if (release_pulse) begin n_rel_obs++; if (first_rel == 0) first_rel = cyc; end
        if (long_pulse && first_long == 0) first_long = cyc;
        if (repeat_pulse && first_rep == 0) first_rep = cyc;
    endtask

    task automatic clear_marks();
        first_press = 0; first_rel = 0; first_long = 0; first_rep = 0;
    endtask

    // Drive the pin (pressed = low) and run n clock edges.
    task automatic hold(input bit p, input int unsigned n);
        pin_p   = p;
        key_raw = ~p;
        repeat (n) tick();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_level"}, 32'(key_level),     0);
        check({tag, "_press"}, 32'(press_pulse),   0);
        check({tag, "_rel"},   32'(release_pulse), 0);
        check({tag, "_long"},  32'(long_pulse),    0);
        check({tag, "_rep"},   32'(repeat_pulse),  0);
        check({tag, "_count"}, 32'(press_count),   0);
    endtask

    task automatic pulse_reset();
        #2 sys_rst_n = 1'b0;
        #1 model_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    initial begin
        int unsigned e1, g1;
        model_reset();

        // Reset state
        #3;
        check_outputs_zero("reset");
        repeat (2) tick();
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        hold(0, 5);

        // Bounce reject: 3 cycles low then released
        hold(1, 3);
        hold(0, 12);
        check("bounce_count", 32'(press_count), 0);
        check("bounce_level", 32'(key_level),   0);

        // Clean press, long hold with repeats, clean release
        clear_marks();
        e1 = cyc + 1;
        hold(1, 7 + LNG + 20);
        check("press_latency",  first_press, e1 + DEB + 2);
        check("long_after_press", first_long - first_press, LNG);
        check("rep_after_long",   first_rep - first_long,   REP);
        check("press_count_1",    32'(press_count), 1);
        e1 = cyc + 1;
        hold(0, 12);
        check("release_latency", first_rel, e1 + DEB + 2);
        check("release_level",   32'(key_level), 0);

        // Release bounce while in LONG: 2-cycle high glitch
        clear_marks();
        e1 = cyc + 1;
        hold(1, 28);
        check("glitch_setup_long", first_long, e1 + DEB + 2 + LNG);
        first_rep = 0;
        g1 = cyc + 1;
        hold(0, 2);
        hold(1, 20);
        check("glitch_no_release", first_rel, 0);
        check("glitch_rep",        first_rep, g1 + 4 + REP);
        hold(0, 12);

        // Random pin activity
        for (int i = 0; i < 250; i++) begin
            int unsigned len;
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(20, 45) : $urandom_range(1, 10);
            hold(1'($urandom_range(0, 1)), len);
        end

        // Wrap of the press counter after 256 clean presses
        pulse_reset();
        hold(0, 4);
        n_press_obs = 0;
        n_rel_obs   = 0;
        for (int i = 0; i < 256; i++) begin
            hold(1, DEB + 4);
            hold(0, DEB + 4);
        end
        check("wrap_count",    32'(press_count), 0);
        check("wrap_presses",  n_press_obs, 256);
        check("wrap_releases", n_rel_obs,   256);

        // Asynchronous reset while held, key stays pressed through reset
        hold(1, DEB + 8);
        check("pre_reset_level", 32'(key_level), 1);
        #2 sys_rst_n = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        model_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        clear_marks();
        e1 = cyc + 1;
        hold(1, 12);
        check("post_reset_press", first_press, e1 + DEB + 2);
        check("post_reset_count", 32'(press_count), 1);
        hold(0, 12);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
